multi_port_fifo: RTL and testbench

//   Parametrised N-lane in-order FIFO: up to LANES pushes and LANES pops per cycle, all-or-nothing

---
 rtl/multi_port_fifo.sv | 151 +++++++++++++++
 tb/tb_multi_port_fifo.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/multi_port_fifo.sv
// ---------------------------------------------------------------------------
// multi_port_fifo
//   In-order FIFO that accepts up to LANES pushes and LANES pops per cycle.
//   Each push group and each pop group is accepted or rejected as a whole.
//   With INIT_FREELIST=1 it comes out of reset/flush full, with entry i = i,
//   so it can hold the free physical registers for rename. With
//   INIT_FREELIST=0 it comes out of reset/flush empty and works as a plain
//   uop queue.
//
// Ports
//   clk           clock
//   rst           synchronous reset, active-low
//   flush_i       return to the reset state on the next edge
//   put_en_i      per-lane push requests; enabled lanes are packed in order
//   put_data_i    per-lane push data
//   put_accept_o  the whole push group is taken this cycle
//   get_en_i      per-lane pop requests; enabled lanes are packed in order
//   get_data_o    per-lane pop data, read combinationally from the head
//   get_valid_o   per-lane pop valid (get_en_i[k] & get_accept_o)
//   get_accept_o  the whole pop group is taken this cycle
//   count_o       registered occupancy
//   free_slots_o  registered DEPTH - occupancy
// ---------------------------------------------------------------------------
module multi_port_fifo #(
  parameter int DEPTH         = 64,
  parameter int WIDTH         = 6,
  parameter int LANES         = 3,
  parameter int INIT_FREELIST = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          flush_i,
  input  logic [LANES-1:0]              put_en_i,
  input  logic [LANES-1:0][WIDTH-1:0]   put_data_i,
  output logic                          put_accept_o,
  input  logic [LANES-1:0]              get_en_i,
  output logic [LANES-1:0][WIDTH-1:0]   get_data_o,
  output logic [LANES-1:0]              get_valid_o,
  output logic                          get_accept_o,
  output logic [$clog2(DEPTH):0]        count_o,
  output logic [$clog2(DEPTH):0]        free_slots_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int NW = $clog2(LANES) + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];

  // Pointers carry one extra wrap bit so that full and empty differ.
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [PW-1:0] count_q, count_d;
  logic [PW-1:0] free_q, free_d;

  logic [NW-1:0] putOff [LANES];
  logic [NW-1:0] getOff [LANES];
  logic [NW-1:0] nPut;
  logic [NW-1:0] nGet;
  logic [AW-1:0] wrIdx [LANES];
  logic [AW-1:0] rdIdx [LANES];
  logic          putAccept;
  logic          getAccept;

  // Running popcount: each enabled lane's offset is the number of enabled
  // lanes below it, so sparse patterns land in consecutive entries.
  always_comb begin
    nPut = '0;
    nGet = '0;
    for (int k = 0; k < LANES; k++) begin
      putOff[k] = nPut;
      getOff[k] = nGet;
      nPut      = nPut + NW'(put_en_i[k]);
      nGet      = nGet + NW'(get_en_i[k]);
    end
  end

  // Acceptance uses the occupancy from the start of the cycle. A slot freed
  // by a pop in this cycle cannot be reused by a push in the same cycle.
  assign getAccept = rst & ~flush_i & (PW'(nGet) <= count_q) & (nGet != '0);
  assign putAccept = rst & ~flush_i & (PW'(nPut) <= free_q)  & (nPut != '0);

  assign get_accept_o = getAccept;
  assign put_accept_o = putAccept;

  // Lane addresses wrap modulo DEPTH because the low pointer bits are used.
  // Data on lanes that are not valid is forced to zero.
  always_comb begin
    for (int k = 0; k < LANES; k++) begin
      wrIdx[k]       = tail_q[AW-1:0] + AW'(putOff[k]);
      rdIdx[k]       = head_q[AW-1:0] + AW'(getOff[k]);
      get_valid_o[k] = get_en_i[k] & getAccept;
      get_data_o[k]  = get_valid_o[k] ? mem_q[rdIdx[k]] : '0;
    end
  end

  assign head_d  = head_q + (getAccept ? PW'(nGet) : '0);
  assign tail_d  = tail_q + (putAccept ? PW'(nPut) : '0);
  assign count_d = tail_d - head_d;
  assign free_d  = PW'(DEPTH) - count_d;

  // Pointer and count registers. Flush returns them to the same state that
  // reset does.
  always_ff @(posedge clk) begin
    if (!rst || flush_i) begin
      head_q <= '0;
      if (INIT_FREELIST != 0) begin
        tail_q  <= PW'(DEPTH);
        count_q <= PW'(DEPTH);
        free_q  <= '0;
      end else begin
        tail_q  <= '0;
        count_q <= '0;
        free_q  <= PW'(DEPTH);
      end
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      free_q  <= free_d;
    end
  end

  // Storage. In free-list mode, reset and flush reload the identity mapping.
  // In queue mode the contents are left alone because the pointers already
  // mark them empty.
  always_ff @(posedge clk) begin
    if ((!rst || flush_i) && (INIT_FREELIST != 0)) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= WIDTH'(i);
      end
    end else if (putAccept) begin
      for (int k = 0; k < LANES; k++) begin
        if (put_en_i[k]) begin
          mem_q[wrIdx[k]] <= put_data_i[k];
        end
      end
    end
  end

  assign count_o      = count_q;
  assign free_slots_o = free_q;

  // Parameter sanity: pointer wrap depends on DEPTH being a power of two,
  // and identity preload needs entries wide enough to hold every index.
  always_ff @(posedge clk) begin
    assert (DEPTH == (1 << AW));
    assert ((INIT_FREELIST == 0) || (WIDTH >= AW));
  end

endmodule

// File: tb/tb_multi_port_fifo.sv
// ---------------------------------------------------------------------------
// tb_multi_port_fifo
//   Directed bench for multi_port_fifo with DEPTH=8, WIDTH=4, LANES=3.
//   Two instances run side by side: dutF is the free-list variant and dutQ
//   is the queue variant. Expected values are hand-computed constants.
//   Packed lane data is written {lane2, lane1, lane0}, one hex digit per lane.
// ---------------------------------------------------------------------------
module tb_multi_port_fifo;

  logic        clk;
  logic        rst;

  logic        fFlush, qFlush;
  logic [2:0]  fPutEn, qPutEn, fGetEn, qGetEn;
  logic [2:0][3:0] fPutData, qPutData;
  logic [2:0][3:0] fGetData, qGetData;
  logic [2:0]  fGetValid, qGetValid;
  logic        fPutAcc, qPutAcc, fGetAcc, qGetAcc;
  logic [3:0]  fCount, qCount, fFree, qFree;

  int checks;
  int errors;

  multi_port_fifo #(.DEPTH(8), .WIDTH(4), .LANES(3), .INIT_FREELIST(1)) dutF (
    .clk(clk), .rst(rst), .flush_i(fFlush),
    .put_en_i(fPutEn), .put_data_i(fPutData), .put_accept_o(fPutAcc),
    .get_en_i(fGetEn), .get_data_o(fGetData), .get_valid_o(fGetValid),
    .get_accept_o(fGetAcc), .count_o(fCount), .free_slots_o(fFree)
  );

  multi_port_fifo #(.DEPTH(8), .WIDTH(4), .LANES(3), .INIT_FREELIST(0)) dutQ (
    .clk(clk), .rst(rst), .flush_i(qFlush),
    .put_en_i(qPutEn), .put_data_i(qPutData), .put_accept_o(qPutAcc),
    .get_en_i(qGetEn), .get_data_o(qGetData), .get_valid_o(qGetValid),
    .get_accept_o(qGetAcc), .count_o(qCount), .free_slots_o(qFree)
  );

  // Free-running clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Drive one instance's request lanes. The other instance is not touched.
  task automatic applyStimulus(input bit isF, input logic [2:0] pe,
                               input logic [11:0] pd, input logic [2:0] ge);
    if (isF) begin
      fPutEn = pe; fPutData = pd; fGetEn = ge;
    end else begin
      qPutEn = pe; qPutData = pd; qGetEn = ge;
    end
    #1;
  endtask

  // Compare one observed value with its expected value.
  task automatic checkOutput(input string tag, input logic [15:0] obs,
                             input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to the next edge and settle to 1 time unit after it.
  task automatic stepClock();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b0;
    fFlush = 1'b0;
    qFlush = 1'b0;
    applyStimulus(1'b0, 3'b000, 12'h000, 3'b000);
    applyStimulus(1'b1, 3'b000, 12'h000, 3'b111);

    // Outputs while reset is held low.
    checkOutput("rstGetAcc",   16'(fGetAcc),   16'h0);
    checkOutput("rstPutAcc",   16'(fPutAcc),   16'h0);
    checkOutput("rstGetValid", 16'(fGetValid), 16'h0);
    checkOutput("rstGetData",  16'(fGetData),  16'h000);
    stepClock();
    rst = 1'b1;
    checkOutput("rstFCount", 16'(fCount), 16'd8);
    checkOutput("rstFFree",  16'(fFree),  16'd0);
    checkOutput("rstQCount", 16'(qCount), 16'd0);
    checkOutput("rstQFree",  16'(qFree),  16'd8);

    // Free list: pop all three lanes.
    applyStimulus(1'b1, 3'b000, 12'h000, 3'b111);
    checkOutput("t1GetAcc",   16'(fGetAcc),   16'h1);
    checkOutput("t1GetValid", 16'(fGetValid), 16'h7);
    checkOutput("t1GetData",  16'(fGetData),  16'h210);
    stepClock();
    checkOutput("t1Count", 16'(fCount), 16'd5);
    checkOutput("t1Free",  16'(fFree),  16'd3);

    // Free list: sparse pop 101 alongside a push of 011.
    applyStimulus(1'b1, 3'b011, 12'h0A9, 3'b101);
    checkOutput("t2GetValid", 16'(fGetValid), 16'h5);
    checkOutput("t2GetData",  16'(fGetData),  16'h403);
    checkOutput("t2PutAcc",   16'(fPutAcc),   16'h1);
    stepClock();
    checkOutput("t2Count", 16'(fCount), 16'd5);

    // Single-lane pop brings the free list to 4.
    applyStimulus(1'b1, 3'b000, 12'h000, 3'b001);
    checkOutput("fPopOneData", 16'(fGetData), 16'h005);
    stepClock();
    applyStimulus(1'b1, 3'b000, 12'h000, 3'b000);
    checkOutput("fPopOneCount", 16'(fCount), 16'd4);

    // Queue: data pushed this cycle cannot be popped in the same cycle.
    applyStimulus(1'b0, 3'b111, 12'h321, 3'b111);
    checkOutput("t3GetAccSame", 16'(qGetAcc), 16'h0);
    checkOutput("t3PutAcc",     16'(qPutAcc), 16'h1);
    stepClock();
    applyStimulus(1'b0, 3'b000, 12'h000, 3'b111);
    checkOutput("t3GetData", 16'(qGetData), 16'h321);
    checkOutput("t3GetAcc",  16'(qGetAcc),  16'h1);
    stepClock();
    checkOutput("t3Count", 16'(qCount), 16'd0);

    // Queue: fill to 7, reject a 2-lane group, accept 1, reach full.
    applyStimulus(1'b0, 3'b111, 12'h654, 3'b000);
    stepClock();
    applyStimulus(1'b0, 3'b111, 12'h987, 3'b000);
    stepClock();
    applyStimulus(1'b0, 3'b001, 12'h00A, 3'b000);
    stepClock();
    checkOutput("t4Count7", 16'(qCount), 16'd7);
    applyStimulus(1'b0, 3'b011, 12'h0CB, 3'b000);
    checkOutput("t4PutRej", 16'(qPutAcc), 16'h0);
    stepClock();
    checkOutput("t4CountHeld", 16'(qCount), 16'd7);
    applyStimulus(1'b0, 3'b001, 12'h00B, 3'b000);
    checkOutput("t4PutAcc", 16'(qPutAcc), 16'h1);
    stepClock();
    checkOutput("t4CountFull", 16'(qCount), 16'd8);
    checkOutput("t4FreeFull",  16'(qFree),  16'd0);

    // Drain; the second group straddles index 7 -> 0.
    applyStimulus(1'b0, 3'b000, 12'h000, 3'b111);
    checkOutput("drain1", 16'(qGetData), 16'h654);
    stepClock();
    applyStimulus(1'b0, 3'b000, 12'h000, 3'b111);
    checkOutput("drain2", 16'(qGetData), 16'h987);
    stepClock();
    applyStimulus(1'b0, 3'b000, 12'h000, 3'b110);
    checkOutput("drain3Data",  16'(qGetData),  16'hBA0);
    checkOutput("drain3Valid", 16'(qGetValid), 16'h6);
    stepClock();
    checkOutput("drainCount", 16'(qCount), 16'd0);

    // Queue: flush at count 4 with full requests on both sides.
    applyStimulus(1'b0, 3'b111, 12'h321, 3'b000);
    stepClock();
    applyStimulus(1'b0, 3'b001, 12'h004, 3'b000);
    stepClock();
    checkOutput("t6QCount4", 16'(qCount), 16'd4);
    qFlush = 1'b1;
    applyStimulus(1'b0, 3'b111, 12'h777, 3'b111);
    checkOutput("t6QPutAcc", 16'(qPutAcc), 16'h0);
    checkOutput("t6QGetAcc", 16'(qGetAcc), 16'h0);
    stepClock();
    qFlush = 1'b0;
    applyStimulus(1'b0, 3'b000, 12'h000, 3'b000);
    checkOutput("t6QCount", 16'(qCount), 16'd0);
    checkOutput("t6QFree",  16'(qFree),  16'd8);

    // Queue wrap: after flush, push 6 and pop 3, then push A,B,C at 6,7,0.
    applyStimulus(1'b0, 3'b111, 12'h321, 3'b000);
    stepClock();
    applyStimulus(1'b0, 3'b111, 12'h654, 3'b111);
    checkOutput("t5Pop1", 16'(qGetData), 16'h321);
    stepClock();
    applyStimulus(1'b0, 3'b111, 12'hCBA, 3'b111);
    checkOutput("t5Pop2",   16'(qGetData), 16'h654);
    checkOutput("t5PutAcc", 16'(qPutAcc),  16'h1);
    stepClock();
    checkOutput("t5Count", 16'(qCount), 16'd3);
    applyStimulus(1'b0, 3'b000, 12'h000, 3'b111);
    checkOutput("t5PopWrap", 16'(qGetData), 16'hCBA);
    stepClock();
    applyStimulus(1'b0, 3'b000, 12'h000, 3'b000);
    checkOutput("t5CountEnd", 16'(qCount), 16'd0);

    // Free list: flush at count 4 reloads the identity contents.
    fFlush = 1'b1;
    applyStimulus(1'b1, 3'b111, 12'hFFF, 3'b111);
    checkOutput("t6FPutAcc", 16'(fPutAcc), 16'h0);
    checkOutput("t6FGetAcc", 16'(fGetAcc), 16'h0);
    stepClock();
    fFlush = 1'b0;
    applyStimulus(1'b1, 3'b000, 12'h000, 3'b000);
    checkOutput("t6FCount", 16'(fCount), 16'd8);
    checkOutput("t6FFree",  16'(fFree),  16'd0);
    applyStimulus(1'b1, 3'b000, 12'h000, 3'b111);
    checkOutput("t6FPopData", 16'(fGetData), 16'h210);
    stepClock();
    applyStimulus(1'b1, 3'b000, 12'h000, 3'b000);
    checkOutput("t6FCountAfter", 16'(fCount), 16'd5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
